vita_time_core: RTL
===================

# vita_time_core

Parametrised free-running VITA time counter, successor to the fixed 32/32-bit timekeeper. It keeps seconds/ticks of configurable width and selects one of NUM_PPS PPS inputs with per-selection polarity. Time can be loaded immediately or on the next PPS edge. A PPS monitor measures the period between edges and declares lock. Sits beside the settings bus in the radio core and feeds vita_time to all DSP/VITA framers.

## Interface
- SECS_W, 32: seconds field width (1..32)
- TICKS_W, 32: ticks field width (1..32)
- NUM_PPS, 2: number of PPS inputs (1..8)
- TICKS_PER_SEC, 32'd100000000: reset value of TPS register
- PPS_TOL, 32'd100: allowed ± deviation (ticks) of measured PPS period
- LOCK_COUNT, 3: consecutive in-tolerance periods required for lock
- BASE, 0: settings base address
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- set_stb  in  1  settings strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- pps  in  NUM_PPS  asynchronous PPS inputs
- vita_time  out  SECS_W+TICKS_W  {seconds,ticks}, registered
- vita_time_pps  out  SECS_W+TICKS_W  vita_time captured at last PPS edge
- pps_int  out  1  one-cycle pulse per selected PPS edge
- pps_period  out  32  last measured PPS period in clk cycles
- pps_locked  out  1  PPS monitor lock
- set_done  out  1  one-cycle pulse when presets are loaded
- armed  out  1  load pending

## Operation
- Registers: BASE+0 NEXT_SECS (write arms a load), BASE+1 NEXT_TICKS, BASE+2 CTRL ([0] mode: 0 next-PPS, 1 immediate; [1] polarity: 0 rising, 1 falling; [4:2] pps_sel; bit [5] write 1 = cancel arm), BASE+3 TPS. Data bits above field width ignored; pps_sel ≥ NUM_PPS selects input 0.
- PPS path: pps[pps_sel] → 2-flop synchroniser → XOR polarity → delay flop; edge = cur & ~del.
- Counter priority: load (armed & (immediate | edge)) > rollover > increment.
- Rollover: if ticks+1 ≥ TPS then ticks←0, seconds←seconds+1 (mod 2^SECS_W); else ticks←ticks+1. Comparison at 32 bits with ticks zero-extended.
- Load: seconds←NEXT_SECS, ticks←NEXT_TICKS; armed clears; set_done pulses same cycle the counters load.
- NEXT_SECS write sets armed one cycle after the strobe edge; an edge coinciding with that strobe does not load. Cancel clears armed; cancel and arm in the same strobe is impossible (different addresses).
- Monitor: period counter counts clocks since last edge, saturating at 2^32−1. On edge: pps_period←count+1, count←0; if TPS−PPS_TOL ≤ count+1 ≤ TPS+PPS_TOL, good_cnt increments (saturating at LOCK_COUNT), else good_cnt←0. pps_locked = good_cnt==LOCK_COUNT. Count exceeding TPS+PPS_TOL without edge clears good_cnt and lock immediately. Changing pps_sel or polarity clears good_cnt.
- vita_time_pps captured from vita_time on edge cycle.

## Timing
- Reset: seconds, ticks, vita_time, vita_time_pps, pps_period, pps_int, pps_locked, set_done, armed = 0; TPS = TICKS_PER_SEC; CTRL = 0; presets = 0.
- vita_time lags internal counter by 1 cycle.
- Immediate mode: NEXT_SECS strobe at edge N → armed after N → counters load at N+1 → vita_time shows preset after N+2.
- PPS input transition to pps_int: 3 clk edges (2 sync + delay).
- Preset ticks ≥ TPS: rolls over on the following cycle.
- TPS lowered below current ticks: rollover on next cycle. TPS of 0 or 1: ticks held at 0, seconds increment every cycle.
- Reset asserted mid-operation clears armed; no load occurs after release until re-armed.

## Test plan
- TPS=10 after reset: 25 cycles → vita_time reaches {2,4}; seconds wrap with SECS_W=4 at 16→0.
- Immediate mode: write NEXT_TICKS=5, NEXT_SECS=7 → set_done pulses once; vita_time={7,5} two cycles after strobe; armed=0.
- Next-PPS mode, pps_sel=1, falling: arm {3,0}; rising on pps[1] → no load; falling → load, pps_int 3 cycles after input edge, vita_time_pps holds pre-load time.
- Monitor, TPS=1000, TOL=2, LOCK_COUNT=3: edges every 1000 cycles → pps_locked after third edge, pps_period=1000; period 1005 → unlock; no edge for 1003 cycles → unlock immediately.
- Arm, then cancel via CTRL[5] before PPS → no load, set_done stays 0; edge coincident with NEXT_SECS strobe → no load, next edge loads.
- Assert rst while armed mid-second → all outputs 0, TPS back to default, following PPS does not load.

Source files
------------

// File: rtl/vita_time_core.sv
// VITA time core: free-running {seconds,ticks} counter with selectable PPS input,
// immediate or PPS-timed preset loading, and a PPS period/lock monitor.
module vita_time_core #(
    parameter int          SECS_W        = 32,
    parameter int          TICKS_W       = 32,
    parameter int          NUM_PPS       = 2,
    parameter logic [31:0] TICKS_PER_SEC = 32'd100000000,
    parameter logic [31:0] PPS_TOL       = 32'd100,
    parameter int          LOCK_COUNT    = 3,
    parameter int          BASE          = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set_stb,
    input  logic [7:0]                 set_addr,
    input  logic [31:0]                set_data,
    input  logic [NUM_PPS-1:0]         pps,
    output logic [SECS_W+TICKS_W-1:0]  vita_time,
    output logic [SECS_W+TICKS_W-1:0]  vita_time_pps,
    output logic                       pps_int,
    output logic [31:0]                pps_period,
    output logic                       pps_locked,
    output logic                       set_done,
    output logic                       armed
);

    localparam int TIME_W = SECS_W + TICKS_W;
    localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_MAX = GOOD_W'(LOCK_COUNT);

    localparam logic [7:0] ADDR_NEXT_SECS  = 8'(BASE);
    localparam logic [7:0] ADDR_NEXT_TICKS = 8'(BASE) + 8'd1;
    localparam logic [7:0] ADDR_CTRL       = 8'(BASE) + 8'd2;
    localparam logic [7:0] ADDR_TPS        = 8'(BASE) + 8'd3;

    logic [SECS_W-1:0]  secs_r;
    logic [SECS_W-1:0]  next_secs_r;
    logic [TICKS_W-1:0] ticks_r;
    logic [TICKS_W-1:0] next_ticks_r;
    logic               mode_r;
    logic               pol_r;
    logic [2:0]         sel_r;
    logic [31:0]        tps_r;
    logic               armed_r;
    logic               set_done_r;
    logic               pps_int_r;
    logic               pps_locked_r;
    logic [TIME_W-1:0]  vita_time_r;
    logic [TIME_W-1:0]  vita_time_pps_r;
    logic [31:0]        period_cnt_r;
    logic [31:0]        pps_period_r;
    logic [GOOD_W-1:0]  good_r;
    logic               sync1_r;
    logic               sync2_r;
    logic               del_r;

    logic               wr_secs_s;
    logic               wr_ticks_s;
    logic               wr_ctrl_s;
    logic               wr_tps_s;
    logic               cancel_s;
    logic               sel_chg_s;
    logic [7:0]         pps_pad_s;
    logic               pps_mux_s;
    logic               cur_s;
    logic               edge_s;
    logic               load_s;
    logic [31:0]        ticks_ext_s;
    logic [32:0]        tick_inc_s;
    logic               roll_s;
    logic [32:0]        cnt_inc_s;
    logic [31:0]        meas_s;
    logic [32:0]        tol_lo_s;
    logic [32:0]        tol_hi_s;
    logic               in_tol_s;
    logic               over_s;
    logic [GOOD_W-1:0]  good_next_s;
    logic               unused_s;

    // Settings bus decode; only the low field bits of set_data are consumed.
    always_comb begin
        wr_secs_s  = set_stb && (set_addr == ADDR_NEXT_SECS);
        wr_ticks_s = set_stb && (set_addr == ADDR_NEXT_TICKS);
        wr_ctrl_s  = set_stb && (set_addr == ADDR_CTRL);
        wr_tps_s   = set_stb && (set_addr == ADDR_TPS);
        cancel_s   = wr_ctrl_s && set_data[5];
        sel_chg_s  = wr_ctrl_s && ((set_data[4:2] != sel_r) || (set_data[1] != pol_r));
    end

    assign unused_s = ^set_data;

    // PPS input select; out-of-range selections fall back to input 0.
    always_comb begin
        pps_pad_s = 8'(pps);
        if (32'(sel_r) < 32'(NUM_PPS)) begin
            pps_mux_s = pps_pad_s[sel_r];
        end else begin
            pps_mux_s = pps[0];
        end
        cur_s  = sync2_r ^ pol_r;
        edge_s = cur_s & ~del_r;
        load_s = armed_r & (mode_r | edge_s);
    end

    // Rollover test is done in 33 bits so the tick increment can never wrap.
    always_comb begin
        ticks_ext_s = 32'(ticks_r);
        tick_inc_s  = {1'b0, ticks_ext_s} + 33'd1;
        roll_s      = (tick_inc_s >= {1'b0, tps_r});
    end

    // Period measurement and tolerance window, saturating at 2^32-1.
    always_comb begin
        cnt_inc_s = {1'b0, period_cnt_r} + 33'd1;
        if (cnt_inc_s[32]) begin
            meas_s = 32'hFFFF_FFFF;
        end else begin
            meas_s = cnt_inc_s[31:0];
        end
        if (tps_r >= PPS_TOL) begin
            tol_lo_s = {1'b0, tps_r - PPS_TOL};
        end else begin
            tol_lo_s = 33'd0;
        end
        tol_hi_s = {1'b0, tps_r} + {1'b0, PPS_TOL};
        in_tol_s = (cnt_inc_s >= tol_lo_s) && (cnt_inc_s <= tol_hi_s);
        over_s   = (cnt_inc_s > tol_hi_s);
    end

    // Consecutive-good-period counter feeding the lock flag.
    always_comb begin
        good_next_s = good_r;
        if (sel_chg_s) begin
            good_next_s = {GOOD_W{1'b0}};
        end else if (edge_s) begin
            if (in_tol_s && (good_r != LOCK_MAX)) begin
                good_next_s = good_r + GOOD_W'(1'b1);
            end else if (in_tol_s) begin
                good_next_s = good_r;
            end else begin
                good_next_s = {GOOD_W{1'b0}};
            end
        end else if (over_s) begin
            good_next_s = {GOOD_W{1'b0}};
        end else begin
            good_next_s = good_r;
        end
    end

    // Settings registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_secs_r  <= {SECS_W{1'b0}};
            next_ticks_r <= {TICKS_W{1'b0}};
            mode_r       <= 1'b0;
            pol_r        <= 1'b0;
            sel_r        <= 3'd0;
            tps_r        <= TICKS_PER_SEC;
        end else begin
            if (wr_secs_s) begin
                next_secs_r <= set_data[SECS_W-1:0];
            end
            if (wr_ticks_s) begin
                next_ticks_r <= set_data[TICKS_W-1:0];
            end
            if (wr_ctrl_s) begin
                mode_r <= set_data[0];
                pol_r  <= set_data[1];
                sel_r  <= set_data[4:2];
            end
            if (wr_tps_s) begin
                tps_r <= set_data;
            end
        end
    end

    // A NEXT_SECS write arms; a load or a cancel disarms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_r <= 1'b0;
        end else if (wr_secs_s) begin
            armed_r <= 1'b1;
        end else if (load_s || cancel_s) begin
            armed_r <= 1'b0;
        end
    end

    // PPS synchroniser and edge delay flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            del_r   <= 1'b0;
        end else begin
            sync1_r <= pps_mux_s;
            sync2_r <= sync1_r;
            del_r   <= cur_s;
        end
    end

    // Time counter: load beats rollover beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secs_r  <= {SECS_W{1'b0}};
            ticks_r <= {TICKS_W{1'b0}};
        end else if (load_s) begin
            secs_r  <= next_secs_r;
            ticks_r <= next_ticks_r;
        end else if (roll_s) begin
            secs_r  <= secs_r + SECS_W'(1'b1);
            ticks_r <= {TICKS_W{1'b0}};
        end else begin
            ticks_r <= ticks_r + TICKS_W'(1'b1);
        end
    end

    // Registered time outputs and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vita_time_r     <= {TIME_W{1'b0}};
            vita_time_pps_r <= {TIME_W{1'b0}};
            pps_int_r       <= 1'b0;
            set_done_r      <= 1'b0;
        end else begin
            vita_time_r <= {secs_r, ticks_r};
            if (edge_s) begin
                vita_time_pps_r <= vita_time_r;
            end
            pps_int_r  <= edge_s;
            set_done_r <= load_s;
        end
    end

    // PPS period monitor and lock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_r <= 32'd0;
            pps_period_r <= 32'd0;
            good_r       <= {GOOD_W{1'b0}};
            pps_locked_r <= 1'b0;
        end else begin
            if (edge_s) begin
                period_cnt_r <= 32'd0;
                pps_period_r <= meas_s;
            end else begin
                period_cnt_r <= meas_s;
            end
            good_r       <= good_next_s;
            pps_locked_r <= (good_next_s == LOCK_MAX);
        end
    end

    assign vita_time     = vita_time_r;
    assign vita_time_pps = vita_time_pps_r;
    assign pps_int       = pps_int_r;
    assign pps_period    = pps_period_r;
    assign pps_locked    = pps_locked_r;
    assign set_done      = set_done_r;
    assign armed         = armed_r;

endmodule
